sprite_loader: RTL
==================

# sprite_loader

Write-side companion to the 64×64 sprite memory: receives pixel data from an external host over a mode-0 SPI link and issues single-cycle writes into the sprite store. The sprite store is addressed `{col,row}`, column-major. Pixels are streamed in that same order, so the renderer's read side sees exactly what the host sent. The block sits between the chip's SPI pins and the sprite memory write port, in the `clk` domain.

## Interface
Parameters:
- `CHANNEL_BITS`, 2, bits per colour channel; pixel width is `CHANNEL_BITS*3`.
- `ADDR_BITS`, 12, sprite address width (64×64 = 4096 pixels).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `spi_sclk`  in  1  host SPI clock; asynchronous to `clk`.
- `spi_mosi`  in  1  host data; MSB first.
- `spi_csb`  in  1  chip select, active-low.
- `wr_en`  out  1  one-cycle write strobe to the sprite memory.
- `wr_addr`  out  `ADDR_BITS`  write address `{col,row}`.
- `wr_data`  out  `CHANNEL_BITS*3`  pixel value, xRGB222 low bits of the received byte.
- `busy`  out  1  high while a transaction is in progress (synchronized `spi_csb` low).
- `frame_done`  out  1  one-cycle pulse when address `2**ADDR_BITS-1` is written.

## Operation
- **Input synchronization.** `spi_sclk`, `spi_mosi` and `spi_csb` each pass through a 2-flop synchronizer.
- **Bit sampling.** A rising edge of the synchronized sclk shifts the synchronized mosi into an 8-bit shift register, MSB first. A 3-bit counter tracks bit position.
- **Clock ratio.** `clk` must be ≥4× `spi_sclk`.
- **Transaction framing.** Each transaction is one byte stream framed by `spi_csb` low:
  - byte 0: command;
  - bytes 1–2: start address, big-endian; upper `16-ADDR_BITS` bits ignored;
  - bytes 3..n: pixels.
- **FSM states** are IDLE, CMD, ADDR_HI, ADDR_LO, DATA and IGNORE.
  - IDLE → CMD when synchronized csb falls; the bit counter is cleared.
  - CMD: a completed byte equal to `CMD_WRITE` (0x10) goes to ADDR_HI. Any other value goes to IGNORE.
  - ADDR_HI → ADDR_LO on byte complete; the high address bits are loaded.
  - ADDR_LO → DATA on byte complete; the low bits are loaded and `wr_addr` takes the start address.
  - DATA: on each completed byte, `wr_data <= byte[CHANNEL_BITS*3-1:0]` and `wr_en` pulses. The address post-increments after the write.
  - IGNORE: all bytes are discarded until csb rises.
- **Transaction end.** Synchronized csb high in any state forces IDLE on the next `clk`.
  - A partial byte is discarded and no write is issued.
  - `wr_addr` holds its last value.
- **Address wrap.** After `2**ADDR_BITS-1`, the address wraps to 0 and the stream continues.
- **`frame_done`.** Pulses in the same cycle as the `wr_en` whose `wr_addr` is all-ones.
- **Reset.** Asserting `reset_n` low mid-transaction forces:
  - FSM to IDLE;
  - `wr_addr` = 0 and `wr_data` = 0;
  - `wr_en`, `busy` and `frame_done` low;
  - synchronizers to idle levels (csb=1, sclk=0, mosi=0).
- **Restart after reset.** If csb is still low on release, nothing is decoded until csb goes high and then low again.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Synchronizer latency is 2 `clk`, and edge detect adds 1.
- `wr_en` asserts exactly 1 `clk` after the detected sclk rising edge that shifts in bit 0 of a pixel byte. It is high for exactly 1 cycle.
- `wr_addr` and `wr_data` are valid while `wr_en` is high. They are stable until the next write or reset.
- `busy` follows synchronized csb low with 1 `clk` register delay.
- There is no back-pressure: the memory must accept a write every cycle `wr_en` is high.

## Configuration
- `SPRITE_LOADER_COUNT_EN` defined:
  - adds output `wr_count [ADDR_BITS:0]`, the number of pixels written in the current/last transaction;
  - `wr_count` clears to 0 on csb falling edge, increments with each `wr_en`, and saturates at `2**ADDR_BITS`;
  - its reset value is 0.
- Macro undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `sprite_pkg` holds:
  - `SPRITE_ADDR_BITS` = 12;
  - `SPRITE_CMD_WRITE` = 8'h10;
  - the `loader_state_t` enum for the FSM states.
- One sub-module, `spi_rx_sync`:
  - contains the three 2-flop synchronizers plus sclk rise and csb fall/rise edge detectors;
  - outputs `sclk_rise`, `csb_fall`, `csb_high` and `mosi_s`.
- The FSM, shift register and address counter live in `sprite_loader`.

## Test plan
- Reset held, then released with csb high → all outputs 0 and FSM IDLE; no `wr_en` for 100 cycles of random sclk.
- Send 0x10, 0x00, 0x05, then pixels 0x3F, 0x2A → two `wr_en` pulses, (addr 0x005, data 0x3F) then (0x006, 0x2A), each exactly 1 cycle; `busy` high throughout.
- Send 0x10, 0x0F, 0xFF, then 0x01, 0x02 → writes at 0xFFF then 0x000; `frame_done` pulses with the 0xFFF write only.
- Command 0x55 followed by 10 bytes → zero `wr_en`; next transaction with 0x10 writes normally.
- csb raised after 5 bits of a pixel byte → no write, FSM IDLE. Separately, `reset_n` pulsed low mid-DATA → outputs 0 immediately; no write until a new csb frame.
- With `SPRITE_LOADER_COUNT_EN`: 3-pixel transaction → `wr_count` = 3; next csb fall → `wr_count` = 0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite store write path: address width,
// SPI command code and the loader FSM state encoding.
package sprite_pkg;

   localparam int         SPRITE_ADDR_BITS = 12;
   localparam logic [7:0] SPRITE_CMD_WRITE = 8'h10;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR_HI,
      ADDR_LO,
      DATA,
      IGNORE
   } loader_state_t;

endpackage

// File: rtl/spi_rx_sync.sv
// Brings the host SPI pins into the clk domain: 2-flop synchronizers on
// sclk/mosi/csb, sclk rising-edge detect and csb fall/level indications.
module spi_rx_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic spi_sclk,
   input  logic spi_mosi,
   input  logic spi_csb,
   output logic sclk_rise,
   output logic csb_fall,
   output logic csb_high,
   output logic mosi_s
);

   logic [1:0] sclk_sync_reg;
   logic [1:0] mosi_sync_reg;
   logic [1:0] csb_sync_reg;
   logic [1:0] fill_reg;
   logic       sclk_prev_reg;
   logic       csb_prev_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync_reg <= 2'b00;
         mosi_sync_reg <= 2'b00;
         csb_sync_reg  <= 2'b11;
         fill_reg      <= 2'b00;
         sclk_prev_reg <= 1'b0;
         csb_prev_reg  <= 1'b0;
      end else begin
         sclk_sync_reg <= {sclk_sync_reg[0], spi_sclk};
         mosi_sync_reg <= {mosi_sync_reg[0], spi_mosi};
         csb_sync_reg  <= {csb_sync_reg[0], spi_csb};
         fill_reg      <= {fill_reg[0], 1'b1};
         sclk_prev_reg <= sclk_sync_reg[1];
         // Only a csb high that really came from the pin arms the fall
         // detector, so a csb held low across reset release is not a frame.
         csb_prev_reg  <= fill_reg[1] & csb_sync_reg[1];
      end
   end

   assign sclk_rise = sclk_sync_reg[1] & ~sclk_prev_reg;
   assign csb_fall  = csb_prev_reg & ~csb_sync_reg[1];
   assign csb_high  = csb_sync_reg[1];
   assign mosi_s    = mosi_sync_reg[1];

endmodule

// File: rtl/sprite_loader.sv
// SPI-to-sprite-memory write engine: decodes command/address/pixel bytes and
// issues single-cycle writes. SPRITE_LOADER_COUNT_EN adds the wr_count output.
module sprite_loader
   import sprite_pkg::*;
#(
   parameter int CHANNEL_BITS = 2,
   parameter int ADDR_BITS    = SPRITE_ADDR_BITS
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      spi_sclk,
   input  logic                      spi_mosi,
   input  logic                      spi_csb,
   output logic                      wr_en,
   output logic [ADDR_BITS-1:0]      wr_addr,
   output logic [CHANNEL_BITS*3-1:0] wr_data,
   output logic                      busy,
   output logic                      frame_done
`ifdef SPRITE_LOADER_COUNT_EN
   ,
   output logic [ADDR_BITS:0]        wr_count
`endif
);

   localparam int PIX_BITS = CHANNEL_BITS * 3;

   logic                 sclk_rise;
   logic                 csb_fall;
   logic                 csb_high;
   logic                 mosi_s;
   loader_state_t        state_reg;
   logic [6:0]           shift_reg;
   logic [2:0]           bit_cnt_reg;
   logic [ADDR_BITS-9:0] addr_hi_reg;
   logic [ADDR_BITS-1:0] next_addr_reg;
   logic [7:0]           rx_byte;
   logic                 byte_done;

   spi_rx_sync u_sync (
      .clk       (clk),
      .reset_n   (reset_n),
      .spi_sclk  (spi_sclk),
      .spi_mosi  (spi_mosi),
      .spi_csb   (spi_csb),
      .sclk_rise (sclk_rise),
      .csb_fall  (csb_fall),
      .csb_high  (csb_high),
      .mosi_s    (mosi_s)
   );

   // Byte as it will look once the bit arriving this cycle is shifted in.
   assign rx_byte   = {shift_reg, mosi_s};
   assign byte_done = sclk_rise && (bit_cnt_reg == 3'd7);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         shift_reg     <= '0;
         bit_cnt_reg   <= '0;
         addr_hi_reg   <= '0;
         next_addr_reg <= '0;
         wr_en         <= 1'b0;
         wr_addr       <= '0;
         wr_data       <= '0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         busy       <= ~csb_high;
         if (csb_high) begin
            state_reg <= IDLE;
         end else begin
            if (state_reg != IDLE && sclk_rise) begin
               shift_reg   <= rx_byte[6:0];
               bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
            case (state_reg)
               IDLE: begin
                  if (csb_fall) begin
                     state_reg   <= CMD;
                     bit_cnt_reg <= '0;
                  end
               end
               CMD: begin
                  if (byte_done)
                     state_reg <= (rx_byte == SPRITE_CMD_WRITE) ? ADDR_HI : IGNORE;
               end
               ADDR_HI: begin
                  if (byte_done) begin
                     addr_hi_reg <= rx_byte[ADDR_BITS-9:0];
                     state_reg   <= ADDR_LO;
                  end
               end
               ADDR_LO: begin
                  if (byte_done) begin
                     wr_addr       <= {addr_hi_reg, rx_byte};
                     next_addr_reg <= {addr_hi_reg, rx_byte};
                     state_reg     <= DATA;
                  end
               end
               DATA: begin
                  if (byte_done) begin
                     wr_en         <= 1'b1;
                     wr_data       <= rx_byte[PIX_BITS-1:0];
                     wr_addr       <= next_addr_reg;
                     next_addr_reg <= next_addr_reg + ADDR_BITS'(1);
                     frame_done    <= &next_addr_reg;
                  end
               end
               IGNORE: ;
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

`ifdef SPRITE_LOADER_COUNT_EN
   localparam logic [ADDR_BITS:0] COUNT_MAX = {1'b1, {ADDR_BITS{1'b0}}};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         wr_count <= '0;
      else if (csb_fall)
         wr_count <= '0;
      else if (!csb_high && state_reg == DATA && byte_done && wr_count != COUNT_MAX)
         wr_count <= wr_count + (ADDR_BITS + 1)'(1);
   end
`endif

endmodule
